// File: rtl/mem_responder.sv
// Single-port 16-bit memory responder: one request accepted at a time, answered
// after WAIT_CYCLES wait states with a one-cycle ready pulse.
//
// state | meaning
// IDLE  | accepting requests; read+write together raises err
// WAIT  | counting down wait states on the latched request
// RESP  | ready high; write commits on this edge, read data already in rdata
module mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          read,
  input  logic          write,
  input  logic          inst_ld,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata,
  output logic          ready,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   wdata_q;
  logic          accept, illegal, load_rd;
  logic [AW-1:0] ld_addr;

  logic [15:0] mem [0:(1<<AW)-1];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    illegal  = 1'b0;
    case (state)
      IDLE: begin
        if (read && write) begin
          illegal = 1'b1;
        end else if (read || write || inst_ld) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With zero wait states RESP is entered straight from IDLE, so the live
  // request inputs decide the read; otherwise the latched copy does.
  always_comb begin
    load_rd = 1'b0;
    ld_addr = addr_q;
    if (state_nx == RESP) begin
      if (state == IDLE) begin
        load_rd = !write;
        ld_addr = addr;
      end else begin
        load_rd = !wr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata   <= 16'h0000;
      err     <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err   <= illegal;
      if (accept) begin
        wr_q    <= write;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (load_rd) rdata <= mem[ld_addr];
    end
  end

  // Contents survive reset; only the commit of an in-flight write is blocked.
  always_ff @(posedge clk) begin
    if (!reset && state == RESP && wr_q) mem[addr_q] <= wdata_q;
  end

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with 2 wait states and one
// with none, sharing the request inputs.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset, read, write, inst_ld;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata2, rdata0;
  logic        ready2, busy2, err2, ready0, busy0, err0;

  logic        sel;
  logic [15:0] m_rdata;
  logic        m_ready, m_busy, m_err;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] model [256];
  logic [15:0] exp_rdata = 16'h0000;
  logic [15:0] sb [$];

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(2), .AW(8)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .inst_ld(inst_ld),
    .addr(addr), .wdata(wdata), .rdata(rdata2), .ready(ready2), .busy(busy2),
    .err(err2)
  );

  mem_responder #(.WAIT_CYCLES(0), .AW(8)) dut0 (
    .clk(clk), .reset(reset), .read(read), .write(write), .inst_ld(inst_ld),
    .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0), .busy(busy0),
    .err(err0)
  );

  assign m_rdata = sel ? rdata0 : rdata2;
  assign m_ready = sel ? ready0 : ready2;
  assign m_busy  = sel ? busy0  : busy2;
  assign m_err   = sel ? err0   : err2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One-cycle request, then watch the selected instance for w+4 cycles.
  task automatic txn(input string tag, input logic rd, input logic wr, input logic il,
                     input logic [7:0] a, input logic [15:0] wd, input int w,
                     input bit toggle);
    int rc = 0, rcyc = 0, bc = 0, ec = 0, ecyc = 0;
    bit illegal = rd && wr;
    bit is_rd   = !wr && (rd || il);
    read = rd; write = wr; inst_ld = il; addr = a; wdata = wd;
    if (is_rd) sb.push_back(model[a]);
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0; inst_ld = 1'b0;
    if (toggle) begin
      addr  = ~a;
      wdata = ~wd;
    end
    for (int c = 1; c <= w + 4; c++) begin
      @(negedge clk);
      if (m_busy) bc++;
      if (m_err) begin
        ec++;
        ecyc = c;
      end
      if (m_ready) begin
        rc++;
        rcyc = c;
        if (is_rd) begin
          if (sb.size() == 0) check({tag, "_sb_empty"}, 1, 0);
          else check({tag, "_rdata"}, m_rdata, sb.pop_front());
        end
      end
    end
    while (sb.size() != 0) void'(sb.pop_front());
    if (illegal) begin
      check({tag, "_err_cnt"}, ec, 1);
      check({tag, "_err_cyc"}, ecyc, 1);
      check({tag, "_ready_cnt"}, rc, 0);
      check({tag, "_busy_cnt"}, bc, 0);
    end else begin
      check({tag, "_ready_cnt"}, rc, 1);
      check({tag, "_ready_cyc"}, rcyc, w + 1);
      check({tag, "_busy_cnt"}, bc, w + 1);
      check({tag, "_err_cnt"}, ec, 0);
      if (wr) model[a] = wd;
      else exp_rdata = model[a];
    end
    check({tag, "_hold"}, m_rdata, exp_rdata);
  endtask

  initial begin
    int rc;
    sel = 1'b0;
    reset = 1'b1; read = 1'b1; write = 1'b0; inst_ld = 1'b0;
    addr = 8'h00; wdata = 16'h0000;
    #20;
    check("rst_rdata", rdata2, 16'h0000);
    check("rst_ready", ready2, 0);
    check("rst_busy", busy2, 0);
    check("rst_err", err2, 0);
    check("rst_busy0", busy0, 0);
    read = 1'b0;
    reset = 1'b0;

    txn("wr10", 0, 1, 0, 8'h10, 16'hBEEF, 2, 0);
    txn("rd10", 1, 0, 0, 8'h10, 16'h0000, 2, 0);
    txn("rdwr", 1, 1, 0, 8'h10, 16'h0BAD, 2, 0);
    txn("rd10b", 1, 0, 0, 8'h10, 16'h0000, 2, 0);

    txn("wr20", 0, 1, 0, 8'h20, 16'h5555, 2, 0);
    write = 1'b1; addr = 8'h20; wdata = 16'h1234;
    @(posedge clk);
    #1;
    write = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ready2) rc++;
    end
    check("abort_ready", rc, 0);
    check("abort_rdata", rdata2, 16'h0000);
    exp_rdata = 16'h0000;
    txn("rd20", 1, 0, 0, 8'h20, 16'h0000, 2, 0);

    txn("wr31", 0, 1, 0, 8'h31, 16'h1111, 2, 0);
    txn("wr30t", 0, 1, 0, 8'h30, 16'hABCD, 2, 1);
    txn("rd30", 1, 0, 0, 8'h30, 16'h0000, 2, 0);
    txn("rd31", 1, 0, 0, 8'h31, 16'h0000, 2, 0);
    txn("rd30t", 1, 0, 0, 8'h30, 16'h0000, 2, 1);

    txn("fetch10", 0, 0, 1, 8'h10, 16'h0000, 2, 0);
    txn("wrfetch", 0, 1, 1, 8'h40, 16'h7777, 2, 0);
    txn("rd40", 1, 0, 0, 8'h40, 16'h0000, 2, 0);

    sel = 1'b1;
    txn("w0wr50", 0, 1, 0, 8'h50, 16'hC0DE, 0, 0);
    txn("w0rd50", 1, 0, 0, 8'h50, 16'h0000, 0, 0);

    read = 1'b1; inst_ld = 1'b1; addr = 8'h10;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_%0d", c), ready0, c % 2);
      check($sformatf("b2b_err_%0d", c), err0, 0);
      if (ready0) check($sformatf("b2b_rdata_%0d", c), rdata0, model[8'h10]);
    end
    read = 1'b0; inst_ld = 1'b0;
    repeat (6) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, wait states inserted between request acceptance and response (legal 0..15).
REQ-002 Parameter AW, default 8, word-address width; memory depth is 2**AW words of 16 bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 read  input  1  data-read request level from the pipeline.
REQ-006 write  input  1  data-write request level from the pipeline.
REQ-007 inst_ld  input  1  instruction-fetch request level from the pipeline.
REQ-008 addr  input  AW  word address, sampled at acceptance.
REQ-009 wdata  input  16  write data, sampled at acceptance.
REQ-010 rdata  output  16  read/fetch data; held between completions.
REQ-011 ready  output  1  one-cycle completion pulse.
REQ-012 busy  output  1  high from the cycle after acceptance through the ready cycle.
REQ-013 err  output  1  one-cycle pulse flagging an illegal request.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT and RESP; it SHALL accept requests only in IDLE.
REQ-015 In IDLE with read=1 and write=1 together, the block SHALL pulse err for 1 cycle, perform no access, not assert ready, and remain in IDLE.
REQ-016 Otherwise in IDLE, priority SHALL be write > read > inst_ld; the winner, addr and wdata SHALL be latched at acceptance edge N.
REQ-017 After acceptance, the FSM SHALL go to WAIT with counter = WAIT_CYCLES, or directly to RESP when WAIT_CYCLES = 0.
REQ-018 In WAIT the counter SHALL decrement each cycle; at counter = 1 the next state SHALL be RESP.
REQ-019 ready SHALL be high exactly in cycle N+WAIT_CYCLES+1 (RESP); RESP SHALL return to IDLE after 1 cycle.
REQ-020 For a latched write, mem[addr] SHALL be updated at the RESP edge; rdata SHALL be unchanged.
REQ-021 For a latched read or inst_ld, rdata SHALL be loaded with mem[addr] at RESP entry, so it is valid while ready=1, and SHALL be held until the next read/fetch completion.
REQ-022 Request inputs SHALL be ignored while busy=1, including changes to addr or wdata; only latched values are used.
REQ-023 A request held high through RESP SHALL be re-accepted in the first IDLE cycle, giving back-to-back transactions every WAIT_CYCLES+2 cycles.
REQ-024 A read after a write to the same address SHALL return the written data, with no hazard window.
REQ-025 Address wrap-around: addr is a direct index and SHALL have no increment or wrap logic.

Reset
REQ-026 While reset=1 at a clock edge, the block SHALL set state IDLE, counter 0, rdata 16'h0000, ready 0, busy 0 and err 0.
REQ-027 Reset mid-transaction SHALL abort the transaction: no ready pulse and no memory write.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 Requests asserted during reset SHALL be accepted no earlier than the first edge with reset=0.

Verification
REQ-030 Reset held 20 time units, then write=1, addr=8'h10, wdata=16'hBEEF for 1 cycle -> busy for 3 cycles, ready on the 3rd cycle after acceptance, err=0.
REQ-031 Then read=1, addr=8'h10 -> ready at N+3 with rdata=16'hBEEF; rdata stays 16'hBEEF after ready falls.
REQ-032 read=1 and write=1 together in IDLE -> err pulse of 1 cycle, no ready, mem[8'h10] is still 16'hBEEF.
REQ-033 read=1 and inst_ld=1 held, addr=8'h10, WAIT_CYCLES=0 -> the read is served first; ready pulses every 2 cycles while the requests are held.
REQ-034 write to 8'h20 with 16'h1234, reset asserted the cycle after acceptance -> no ready; a later read of 8'h20 returns the prior contents, not 16'h1234.
REQ-035 During busy, toggle addr and wdata -> the completed access uses the values latched at acceptance.
